lc3_mem_responder: RTL

Memory-side responder for the LC-3 control unit's memory bus. It answers the multi-cycle Mem_OE (read) and Mem_WE (write) requests driven by the instruction sequencer. Reads and writes go to an internal word array, except that one address is decoded as memory-mapped I/O (switches in, hex display out). It sits between the datapath's MAR/MDR and on-chip storage, and enforces a fixed wait-state count that matches the sequencer's 4-cycle access states.

---
 rtl/lc3_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 Mem_OE/Mem_WE bus: fixed wait-state word array
// with a single memory-mapped I/O address (switches in, hex display out).
module lc3_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned WAIT    = 3,  // legal range 2..15
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Ready,
  output logic [15:0] HEX_Data,
  output logic        Bus_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_HOLD = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR_HOLD = 3'd4;

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [3:0]  LastCnt = 4'(WAIT - 1);

  logic [15:0] mem [Depth];

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        is_io;
  logic [ADDR_W-1:0] word_addr;

  assign is_io     = (addr_q == IO_ADDR);
  assign word_addr = addr_q[ADDR_W-1:0];

  // cnt_q holds the number of request cycles already completed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    err_d   = err_q | (Mem_OE & Mem_WE);
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Mem_WE) begin
          addr_d  = ADDR;
          wdata_d = Data_from_CPU;
          cnt_d   = 4'd1;
          state_d = WR_WAIT;
        end else if (Mem_OE) begin
          addr_d  = ADDR;
          cnt_d   = 4'd1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!Mem_OE || Mem_WE) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == LastCnt) begin
          rdata_d = is_io ? Switches : mem[word_addr];
          cnt_d   = 4'd0;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HOLD: begin
        if (!Mem_OE || Mem_WE) state_d = IDLE;
      end
      WR_WAIT: begin
        if (!Mem_WE) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == LastCnt) begin
          if (is_io) hex_d = wdata_q;
          else       mem_we = 1'b1;
          cnt_d   = 4'd0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HOLD: begin
        if (!Mem_WE) state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      rdata_q <= 16'd0;
      hex_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; reset only suppresses a commit on the same edge.
  always_ff @(posedge Clk) begin
    if (mem_we && Reset) mem[word_addr] <= wdata_q;
  end

  assign Ready       = (state_q == RD_HOLD) || (state_q == WR_HOLD);
  assign Data_to_CPU = rdata_q;
  assign HEX_Data    = hex_q;
  assign Bus_err     = err_q;

endmodule
